tri_bus_rx: RTL and testbench
=============================

# tri_bus_rx

Receive endpoint for the shared tri-state data bus driven by the team's tri-state buffers. Sits on the bus next to any number of drivers:
- samples the bus on a driver strobe and queues words in a small FIFO;
- hands words to local logic over a valid/ready handshake;
- back-pressures drivers with a busy flag when the FIFO is full.

## Interface
Parameters:
- WIDTH, 32, bus/data word width in bits
- DEPTH, 4, FIFO entries; power of two, ≥ 2

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-high
- bus_data  input  WIDTH  shared tri-state bus, read only; never driven by this block
- bus_strb  input  1  driver asserts for one cycle per word while its buffer is enabled
- bus_par  input  1  even parity of bus_data (present only with TRI_BUS_RX_PARITY_EN)
- bus_busy  output  1  registered; high when FIFO full (count == DEPTH)
- rx_data  output  WIDTH  FIFO head word; valid only while rx_valid is high
- rx_valid  output  1  FIFO non-empty
- rx_ready  input  1  consumer accepts head word when high with rx_valid
- count  output  $clog2(DEPTH+1)  current occupancy
- overflow  output  1  sticky: strobe arrived while full
- par_err  output  1  sticky parity error (tied 0 without the macro)
- clr_err  input  1  synchronous clear of overflow and par_err

## Operation
- Push: at a clk edge with bus_strb=1 and count < DEPTH, write bus_data at wr_ptr and increment wr_ptr.
- Full drop: with bus_strb=1 and count == DEPTH, drop the word and set overflow.
  - A simultaneous pop does not rescue the word. Acceptance is decided on pre-edge count only.
- Pop: at a clk edge with rx_valid && rx_ready, increment rd_ptr.
  - rx_ready while rx_valid=0 has no effect.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0. count tracks occupancy separately.
- Outputs derived from state:
  - rx_valid = (count != 0)
  - rx_data = mem[rd_ptr]
  - bus_busy = (count == DEPTH), from registered count
- Sticky error flags:
  - overflow and par_err stay set until clr_err=1 at a clk edge.
  - If clr_err and a new error event coincide, the set wins (flag stays 1).
- bus_data and bus_par are don't-care when bus_strb=0. Z/X on the bus in that case must not corrupt state.

## Timing
- Reset (async assert, released synchronously to clk by the system):
  - count=0, wr_ptr=0, rd_ptr=0
  - rx_valid=0, bus_busy=0, overflow=0, par_err=0
  - FIFO contents not reset; rx_data undefined while rx_valid=0
- Latency: a word strobed at edge N appears on rx_data with rx_valid=1 after edge N (usable at edge N+1).
- bus_busy rises after the edge that makes count reach DEPTH, and falls after the edge that pops from full.
  - Drivers must sample bus_busy before strobing. A driver that strobes in the same cycle busy rises loses the word (overflow).
- Reset mid-operation: all queued words are discarded immediately. A strobe coincident with reset is ignored.
- Throughput: one push and one pop per cycle, sustained.

## Configuration
- TRI_BUS_RX_PARITY_EN defined:
  - bus_par port exists.
  - On an accepted strobe, if ^{bus_data, bus_par} != 0, the word is not written and par_err is set.
  - A parity-failed strobe while full sets both par_err and overflow.
- Undefined:
  - bus_par port is absent.
  - par_err is constant 0.
  - Every strobe with count < DEPTH is accepted.

## Test plan
- Reset, then 1 strobe with bus_data=32'hDEADBEEF and rx_ready=0 -> rx_valid=1, rx_data=32'hDEADBEEF, count=1 on the following cycle.
- 4 strobes (1,2,3,4) with rx_ready=0 -> bus_busy=1 and count=4; 5th strobe (5) -> overflow=1 and count stays 4. Then drain -> 1,2,3,4 in order, with bus_busy falling after the first pop.
- Continuous strobes and rx_ready=1 for 20 cycles -> count constant at 1, 20 words out in order, pointer wrap exercised, overflow=0.
- Full FIFO with strobe and pop on the same edge -> word dropped, overflow=1, count=3. Then clr_err=1 -> overflow=0.
- Assert rst asynchronously with count=3 between edges -> rx_valid and bus_busy go 0 immediately, count=0, no words delivered afterwards.
- With TRI_BUS_RX_PARITY_EN: strobe 32'h00000001 with bus_par=0 -> not queued, par_err=1. Strobe 32'h00000001 with bus_par=1 -> queued, rx_data=32'h00000001.

Source files
------------

// File: rtl/tri_bus_rx.sv
// tri_bus_rx: receive endpoint for the shared tri-state data bus.
// Samples bus_data on bus_strb into a DEPTH-entry FIFO, presents the head
// word on a valid/ready interface and raises bus_busy while the FIFO is full.
// Optional feature macro: TRI_BUS_RX_PARITY_EN (even parity check via bus_par).
module tri_bus_rx #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [WIDTH-1:0]             bus_data,
   input  logic                         bus_strb,
`ifdef TRI_BUS_RX_PARITY_EN
   input  logic                         bus_par,
`endif
   output logic                         bus_busy,
   output logic [WIDTH-1:0]             rx_data,
   output logic                         rx_valid,
   input  logic                         rx_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic                         par_err,
   input  logic                         clr_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Storage is deliberately not reset; only the pointers and count define validity.
   logic [WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] count_reg, count_next;
   logic          busy_reg, busy_next;
   logic          overflow_reg, overflow_next;
   logic          par_err_reg, par_err_next;

   logic full;
   logic par_bad;
   logic push_ok;
   logic pop;
   logic drop_full;

   assign full = (count_reg == FULL_CNT);

`ifdef TRI_BUS_RX_PARITY_EN
   // Parity is only evaluated while strobed so a floating bus cannot raise an error.
   assign par_bad = bus_strb && ((^{bus_data, bus_par}) != 1'b0);
`else
   assign par_bad = 1'b0;
`endif

   // Acceptance depends on the pre-edge count only; a same-edge pop never frees a slot.
   assign push_ok   = bus_strb && !full && !par_bad;
   assign drop_full = bus_strb && full;
   assign pop       = (count_reg != '0) && rx_ready;

   // Next-state for pointers, occupancy, busy and the sticky error flags.
   always_comb begin
      wr_ptr_next   = wr_ptr_reg;
      rd_ptr_next   = rd_ptr_reg;
      count_next    = count_reg;
      overflow_next = overflow_reg;
      par_err_next  = par_err_reg;

      // Pointers are exactly PW bits wide, so DEPTH-1 + 1 wraps to 0 naturally.
      if (push_ok) begin
         wr_ptr_next = wr_ptr_reg + PW'(1);
      end
      if (pop) begin
         rd_ptr_next = rd_ptr_reg + PW'(1);
      end

      case ({push_ok, pop})
         2'b10:   count_next = count_reg + CW'(1);
         2'b01:   count_next = count_reg - CW'(1);
         default: count_next = count_reg;
      endcase

      // Clear first, then set, so a coincident error event keeps the flag high.
      if (clr_err) begin
         overflow_next = 1'b0;
         par_err_next  = 1'b0;
      end
      if (drop_full) begin
         overflow_next = 1'b1;
      end
      if (par_bad) begin
         par_err_next = 1'b1;
      end

      busy_next = (count_next == FULL_CNT);
   end

   // Control state register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         busy_reg     <= 1'b0;
         overflow_reg <= 1'b0;
         par_err_reg  <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
         busy_reg     <= busy_next;
         overflow_reg <= overflow_next;
         par_err_reg  <= par_err_next;
      end
   end

   // FIFO write port; bus contents are only captured on an accepted strobe.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= bus_data;
      end
   end

   assign rx_data  = mem[rd_ptr_reg];
   assign rx_valid = (count_reg != '0);
   assign bus_busy = busy_reg;
   assign count    = count_reg;
   assign overflow = overflow_reg;
`ifdef TRI_BUS_RX_PARITY_EN
   assign par_err  = par_err_reg;
`else
   assign par_err  = 1'b0;
`endif

endmodule

// File: tb/tb_tri_bus_rx.sv
// tb_tri_bus_rx: directed table-driven bench for tri_bus_rx plus hand-written
// sequences for sustained throughput, async reset and (optionally) parity.
module tb_tri_bus_rx;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [WIDTH-1:0]  bus_data;
   logic              bus_strb;
   logic              bus_par;
   logic              bus_busy;
   logic [WIDTH-1:0]  rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic [2:0]        count;
   logic              overflow;
   logic              par_err;
   logic              clr_err;

   int n_checks = 0;
   int n_fail   = 0;

   tri_bus_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus_data (bus_data),
      .bus_strb (bus_strb),
`ifdef TRI_BUS_RX_PARITY_EN
      .bus_par  (bus_par),
`endif
      .bus_busy (bus_busy),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .count    (count),
      .overflow (overflow),
      .par_err  (par_err),
      .clr_err  (clr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        strb;
      logic [31:0] data;
      logic        ready;
      logic        clr;
      logic        exp_valid;
      logic [31:0] exp_data;
      logic [2:0]  exp_count;
      logic        exp_busy;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input string name, input logic strb, input logic [31:0] data,
                      input logic ready, input logic clr, input logic ev,
                      input logic [31:0] ed, input logic [2:0] ec,
                      input logic eb, input logic eo);
      vec_t v;
      v.name = name; v.strb = strb; v.data = data; v.ready = ready; v.clr = clr;
      v.exp_valid = ev; v.exp_data = ed; v.exp_count = ec; v.exp_busy = eb; v.exp_ovf = eo;
      vecs.push_back(v);
   endtask

   // Drive one cycle of inputs, let one rising edge pass, sample 1 time unit later.
   task automatic cycle(input logic strb, input logic [31:0] data, input logic ready, input logic clr);
      bus_strb = strb;
      bus_data = data;
      bus_par  = ^data;
      rx_ready = ready;
      clr_err  = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string name, input logic ev, input logic [31:0] ed,
                              input logic [2:0] ec, input logic eb, input logic eo);
      check({name, ".valid"}, 32'(rx_valid), 32'(ev));
      if (ev) check({name, ".data"}, rx_data, ed);
      check({name, ".count"}, 32'(count), 32'(ec));
      check({name, ".busy"}, 32'(bus_busy), 32'(eb));
      check({name, ".ovf"}, 32'(overflow), 32'(eo));
   endtask

   initial begin
      logic [31:0] zbus;
      zbus = 'z;

      rst = 1'b1; bus_strb = 1'b0; bus_data = zbus; bus_par = 1'b0;
      rx_ready = 1'b0; clr_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_state("reset", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
      check("reset.par_err", 32'(par_err), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // ---------------- table of single-edge vectors ----------------
      //   name         strb data          rdy clr  valid data          cnt busy ovf
      add("first",     1, 32'hDEADBEEF, 0, 0,   1, 32'hDEADBEEF, 3'd1, 0, 0);
      add("pop_first", 0, zbus,         1, 0,   0, 32'h0,        3'd0, 0, 0);
      add("fill1",     1, 32'd1,        0, 0,   1, 32'd1,        3'd1, 0, 0);
      add("fill2",     1, 32'd2,        0, 0,   1, 32'd1,        3'd2, 0, 0);
      add("idle_z",    0, zbus,         0, 0,   1, 32'd1,        3'd2, 0, 0);
      add("fill3",     1, 32'd3,        0, 0,   1, 32'd1,        3'd3, 0, 0);
      add("fill4",     1, 32'd4,        0, 0,   1, 32'd1,        3'd4, 1, 0);
      add("drop5",     1, 32'd5,        0, 0,   1, 32'd1,        3'd4, 1, 1);
      add("drain1",    0, zbus,         1, 0,   1, 32'd2,        3'd3, 0, 1);
      add("drain2",    0, zbus,         1, 0,   1, 32'd3,        3'd2, 0, 1);
      add("drain3",    0, zbus,         1, 0,   1, 32'd4,        3'd1, 0, 1);
      add("drain4",    0, zbus,         1, 0,   0, 32'h0,        3'd0, 0, 1);
      add("rdy_empty", 0, zbus,         1, 0,   0, 32'h0,        3'd0, 0, 1);
      add("clr1",      0, zbus,         0, 1,   0, 32'h0,        3'd0, 0, 0);
      add("f10",       1, 32'h10,       0, 0,   1, 32'h10,       3'd1, 0, 0);
      add("f11",       1, 32'h11,       0, 0,   1, 32'h10,       3'd2, 0, 0);
      add("f12",       1, 32'h12,       0, 0,   1, 32'h10,       3'd3, 0, 0);
      add("f13",       1, 32'h13,       0, 0,   1, 32'h10,       3'd4, 1, 0);
      add("full_pp",   1, 32'h14,       1, 0,   1, 32'h11,       3'd3, 0, 1);
      add("clr2",      0, zbus,         0, 1,   1, 32'h11,       3'd3, 0, 0);
      add("f15",       1, 32'h15,       0, 0,   1, 32'h11,       3'd4, 1, 0);
      add("clr_set",   1, 32'h16,       0, 1,   1, 32'h11,       3'd4, 1, 1);
      add("d11",       0, zbus,         1, 0,   1, 32'h12,       3'd3, 0, 1);
      add("d12",       0, zbus,         1, 0,   1, 32'h13,       3'd2, 0, 1);
      add("d13",       0, zbus,         1, 0,   1, 32'h15,       3'd1, 0, 1);
      add("d15",       0, zbus,         1, 0,   0, 32'h0,        3'd0, 0, 1);
      add("clr3",      0, zbus,         0, 1,   0, 32'h0,        3'd0, 0, 0);

      foreach (vecs[i]) begin
         cycle(vecs[i].strb, vecs[i].data, vecs[i].ready, vecs[i].clr);
         check_state(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_data,
                     vecs[i].exp_count, vecs[i].exp_busy, vecs[i].exp_ovf);
         $display("vec %0d %s: strb=%b data=%h rdy=%b -> valid=%b data=%h count=%0d busy=%b ovf=%b",
                  i, vecs[i].name, vecs[i].strb, vecs[i].data, vecs[i].ready,
                  rx_valid, rx_data, count, bus_busy, overflow);
      end
      check("table.par_err", 32'(par_err), 32'h0);

      // ---------------- sustained push+pop, 20 cycles ----------------
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
         check($sformatf("stream%0d.count", i), 32'(count), 32'd1);
         check($sformatf("stream%0d.data", i), rx_data, 32'h100 + 32'(i));
         $display("stream %0d: data=%h count=%0d", i, rx_data, count);
      end
      cycle(1'b0, zbus, 1'b1, 1'b0);
      check_state("stream_end", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);

      // ---------------- asynchronous reset with 3 words queued ----------------
      cycle(1'b1, 32'hA1, 1'b0, 1'b0);
      cycle(1'b1, 32'hA2, 1'b0, 1'b0);
      cycle(1'b1, 32'hA3, 1'b0, 1'b0);
      check("pre_rst.count", 32'(count), 32'd3);
      #2 rst = 1'b1;
      #1;
      check_state("async_rst", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
      $display("async reset: valid=%b busy=%b count=%0d", rx_valid, bus_busy, count);
      // strobe coincident with reset must be ignored
      cycle(1'b1, 32'hA4, 1'b1, 1'b0);
      check("rst_strobe.count", 32'(count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b0, zbus, 1'b1, 1'b0);
      check_state("post_rst", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
      cycle(1'b0, zbus, 1'b1, 1'b0);
      check("post_rst2.valid", 32'(rx_valid), 32'h0);

`ifdef TRI_BUS_RX_PARITY_EN
      // ---------------- parity ----------------
      bus_strb = 1'b1; bus_data = 32'h1; bus_par = 1'b0; rx_ready = 1'b0; clr_err = 1'b0;
      @(posedge clk); #1;
      check("par_bad.count", 32'(count), 32'd0);
      check("par_bad.par_err", 32'(par_err), 32'd1);
      bus_strb = 1'b1; bus_data = 32'h1; bus_par = 1'b1;
      @(posedge clk); #1;
      check("par_ok.count", 32'(count), 32'd1);
      check("par_ok.data", rx_data, 32'h1);
      check("par_ok.par_err", 32'(par_err), 32'd1);
      $display("parity: count=%0d data=%h par_err=%b", count, rx_data, par_err);
      cycle(1'b0, zbus, 1'b1, 1'b1);
      check("par_clr.par_err", 32'(par_err), 32'd0);
`else
      // parity disabled: a word with odd parity must be accepted, par_err stays 0
      cycle(1'b1, 32'h1, 1'b0, 1'b0);
      check("nopar.count", 32'(count), 32'd1);
      check("nopar.data", rx_data, 32'h1);
      check("nopar.par_err", 32'(par_err), 32'd0);
      $display("no-parity: count=%0d data=%h par_err=%b", count, rx_data, par_err);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
